ysyx_22040750_npc_queue: RTL
============================

// Module: ysyx_22040750_npc_queue
// PURPOSE
//  Parametrised next-PC generator with a DEPTH-entry pending-target queue, for the IF/ID loop.
//  Computes dnpc from a one-hot selector (trap/jalr/jal/branch/snpc) and hands it to fetch
//  over a valid/ready handshake. Targets are buffered, never dropped, while fetch stalls.
//  Adds a boot/flush redirect slot that overrides all queued targets, plus jalr LSB clear
//  and misalignment flagging.
// PARAMETERS
//  PC_W     32            width of pc/dnpc
//  XLEN     64            width of rs1/imm/trap-pc operands (only [PC_W-1:0] used)
//  DEPTH    2             pending queue entries; power of 2, >=2
//  RST_PC   32'h80000000  first pc issued after reset
//  ALIGN    1             1: check [1:0]==0 (no RVC); 0: check [0]==0 only
// PORTS
//  I_clk        in   1      clock
//  I_rst_n      in   1      synchronous reset, active low
//  I_src_valid  in   1      ID has a resolved next-pc decision
//  O_src_ready  out  1      queue can accept the decision this cycle
//  I_sel        in   5      {trap,jalr,jal,branch_taken,snpc}; priority high->low if not one-hot
//  I_pc         in   PC_W   pc of the deciding instruction (jal/branch base)
//  I_snpc       in   PC_W   sequential next pc
//  I_imm        in   XLEN   immediate offset
//  I_rs1        in   XLEN   rs1 data (jalr base)
//  I_trap_pc    in   XLEN   mtvec/mepc target for trap/xret
//  I_flush      in   1      later-stage redirect: discard all pending targets
//  I_flush_pc   in   PC_W   redirect target
//  O_dnpc_valid out  1      O_dnpc valid toward fetch
//  I_dnpc_ready in   1      fetch accepts O_dnpc
//  O_dnpc       out  PC_W   next pc to fetch
//  O_misalign   out  1      O_dnpc fails the ALIGN check (qualified by O_dnpc_valid)
//  O_count      out  log2(DEPTH)+1  queue occupancy
// BEHAVIOUR
//  Target calc: trap->I_trap_pc; jalr->(rs1+imm)&~1; jal/branch->pc+imm; else (incl. sel==0)->snpc.
//  Sums are mod 2^PC_W. Misalign is computed at calc time and stored per entry.
//  Redirect slot (redir_v, redir_pc): has priority over the queue and bypass.
//   - Reset: redir_v=1, redir_pc=RST_PC, queue empty, count=0.
//   - I_flush: on the next edge queue clears, redir_v=1, redir_pc=I_flush_pc. A later flush overwrites.
//   - Clears on O_dnpc_valid&&I_dnpc_ready while the slot is selected.
//  O_src_ready = !I_flush && !redir_v && count<DEPTH. While I_flush=1 the source is not accepted.
//  Output select: redir_v -> redir_pc; else count!=0 -> queue head; else bypass the computed
//   target when I_src_valid&&O_src_ready. Bypass has zero latency (combinational).
//   O_dnpc_valid = redir_v | (count!=0) | (I_src_valid&O_src_ready).
//  Push: source handshake && !(bypass selected && I_dnpc_ready).
//  Pop: head selected && I_dnpc_ready.
//  Simultaneous push+pop keeps count unchanged and preserves FIFO order. Pointers wrap mod DEPTH.
//  Full: O_src_ready=0, and the queue is held until a pop. Empty with no source: O_dnpc_valid=0.
//  O_dnpc/O_misalign hold stable while O_dnpc_valid&&!I_dnpc_ready, except on flush.
//  Reset mid-operation: all state returns to the reset values above, on the next edge.
// TESTING
//  1 Reset release, I_dnpc_ready=1 -> cycle0 O_dnpc=0x80000000 valid; then valid=0 until a source.
//  2 Bypass: sel=jal, pc=0x80000010, imm=0x20, ready=1 -> same cycle O_dnpc=0x80000030, count=0.
//  3 Stall: ready=0, push snpc 0x80000004 then jalr rs1=0x80001001 imm=0 -> count=2, src_ready=0;
//    raise ready -> 0x80000004 then 0x80001000, in order.
//  4 Flush while count=2: flush_pc=0x80000100 -> next cycle count=0, O_dnpc=0x80000100;
//    the same-cycle source is not accepted.
//  5 Misalign: jal pc=0x80000000 imm=0x2, ALIGN=1 -> O_dnpc=0x80000002, O_misalign=1.
//  6 sel=5'b01100 (jalr+jal) -> jalr target used; sel=0 -> I_snpc used.

Source files
------------

// File: rtl/ysyx_22040750_npc_queue.sv
// Next-PC generator for the IF/ID loop. Computes dnpc from a one-hot selector
// and hands it to fetch, buffering up to DEPTH targets behind a redirect slot.
module ysyx_22040750_npc_queue #(
    parameter int              PC_W   = 32,
    parameter int              XLEN   = 64,
    parameter int              DEPTH  = 2,
    parameter logic [PC_W-1:0] RST_PC = 32'h80000000,
    parameter int              ALIGN  = 1
) (
    input  logic                       I_clk,
    input  logic                       I_rst_n,
    input  logic                       I_src_valid,
    output logic                       O_src_ready,
    input  logic [4:0]                 I_sel,
    input  logic [PC_W-1:0]            I_pc,
    input  logic [PC_W-1:0]            I_snpc,
    input  logic [XLEN-1:0]            I_imm,
    input  logic [XLEN-1:0]            I_rs1,
    input  logic [XLEN-1:0]            I_trap_pc,
    input  logic                       I_flush,
    input  logic [PC_W-1:0]            I_flush_pc,
    output logic                       O_dnpc_valid,
    input  logic                       I_dnpc_ready,
    output logic [PC_W-1:0]            O_dnpc,
    output logic                       O_misalign,
    output logic [$clog2(DEPTH):0]     O_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    function automatic logic is_misaligned(input logic [PC_W-1:0] pc);
        return (ALIGN != 0) ? (pc[1:0] != 2'b00) : pc[0];
    endfunction

    logic [PC_W-1:0] calc_pc;
    logic            calc_mis;
    logic [PC_W-1:0] jalr_sum;
    logic [PC_W-1:0] rel_sum;

    assign jalr_sum = I_rs1[PC_W-1:0] + I_imm[PC_W-1:0];
    assign rel_sum  = I_pc + I_imm[PC_W-1:0];

    // Priority decode: a non-one-hot selector resolves to its highest set bit.
    always_comb begin
        calc_pc = I_snpc;
        if (I_sel[4]) begin
            calc_pc = I_trap_pc[PC_W-1:0];
        end else if (I_sel[3]) begin
            calc_pc = {jalr_sum[PC_W-1:1], 1'b0};
        end else if (I_sel[2] || I_sel[1]) begin
            calc_pc = rel_sum;
        end
    end
    assign calc_mis = is_misaligned(calc_pc);

    generate
        if (XLEN > PC_W) begin : g_upper
            logic unused_upper_bits;
            assign unused_upper_bits = ^{I_rs1[XLEN-1:PC_W], I_imm[XLEN-1:PC_W],
                                         I_trap_pc[XLEN-1:PC_W]};
        end
    endgenerate

    logic             redir_v_q;
    logic [PC_W-1:0]  redir_pc_q;
    logic [PC_W-1:0]  q_pc_q  [DEPTH];
    logic             q_mis_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;

    logic src_hs, sel_head, sel_byp, push, pop;

    assign O_src_ready = !I_flush && !redir_v_q && (count_q < CNT_W'(DEPTH));
    assign src_hs      = I_src_valid && O_src_ready;
    assign sel_head    = !redir_v_q && (count_q != '0);
    assign sel_byp     = !redir_v_q && (count_q == '0) && src_hs;
    assign push        = src_hs && !(sel_byp && I_dnpc_ready);
    assign pop         = sel_head && I_dnpc_ready;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Flush dominates any same-cycle handshake: the slot is re-armed and the queue emptied.
    always_ff @(posedge I_clk) begin
        if (!I_rst_n) begin
            redir_v_q  <= 1'b1;
            redir_pc_q <= RST_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else if (I_flush) begin
            redir_v_q  <= 1'b1;
            redir_pc_q <= I_flush_pc;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            if (redir_v_q && I_dnpc_ready) begin
                redir_v_q <= 1'b0;
            end
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
        end
    end

    always_ff @(posedge I_clk) begin
        if (I_rst_n && !I_flush && push) begin
            q_pc_q[wr_ptr_q]  <= calc_pc;
            q_mis_q[wr_ptr_q] <= calc_mis;
        end
    end

    assign O_dnpc_valid = redir_v_q || (count_q != '0) || src_hs;
    assign O_dnpc       = redir_v_q ? redir_pc_q
                        : sel_head  ? q_pc_q[rd_ptr_q] : calc_pc;
    assign O_misalign   = redir_v_q ? is_misaligned(redir_pc_q)
                        : sel_head  ? q_mis_q[rd_ptr_q] : calc_mis;
    assign O_count      = count_q;
endmodule
